// File: rtl/cam_stream_sequencer_pkg.sv
// Shared types and constants for the camera FIFO to AXI4-Stream video sequencer.
// Field offsets are given relative to the pixel width so every DATA_W shares one word layout.
package cam_stream_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSync   = 2'd1,
    StVblank = 2'd2,
    StActive = 2'd3
  } state_e;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_CNT_W    = 10;

  // FIFO word is {vsync, href, pixel[DATA_W-1:0]}
  localparam int unsigned VSYNC_BIT = DEF_DATA_W + 1;
  localparam int unsigned HREF_BIT  = DEF_DATA_W;

  function automatic int unsigned vsync_bit(input int unsigned data_w);
    return data_w + 1;
  endfunction

  function automatic int unsigned href_bit(input int unsigned data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/cam_stream_sequencer_if.sv
// AXI4-Stream video channel carrying pixels, start-of-frame (tuser) and end-of-line (tlast).
interface cam_stream_sequencer_if
  import cam_stream_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tuser;
  logic              tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);

endinterface

// File: rtl/cam_stream_sequencer_axis_out_reg.sv
// Single-stage AXI4-Stream output register: loads a beat, holds it while stalled,
// and drops tvalid on handshake unless a new beat replaces it in the same cycle.
module axis_out_reg
  import cam_stream_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              user,
  input  logic              last,
  cam_stream_sequencer_if.master axis
);

  logic [DATA_W-1:0] tdata_q;
  logic              tvalid_q;
  logic              tuser_q;
  logic              tlast_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
    end else if (load) begin
      tdata_q  <= data;
      tvalid_q <= 1'b1;
      tuser_q  <= user;
      tlast_q  <= last;
    end else if (axis.tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign axis.tdata  = tdata_q;
  assign axis.tvalid = tvalid_q;
  assign axis.tuser  = tuser_q;
  assign axis.tlast  = tlast_q;

endmodule

// File: rtl/cam_stream_sequencer.sv
// Locks onto vsync/href embedded in FWFT camera FIFO words and emits exactly
// H_ACTIVE x V_ACTIVE AXI4-Stream video beats per frame.
module cam_stream_sequencer
  import cam_stream_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic [DATA_W+1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  cam_stream_sequencer_if.master m_axis_video,
  output logic              frame_done,
  output logic              frame_err,
  output logic [15:0]       frame_count,
  output logic              busy
);

  localparam int unsigned VsyncIdx = vsync_bit(DATA_W);
  localparam int unsigned HrefIdx  = href_bit(DATA_W);

  state_e            state_q;
  logic [CNT_W-1:0]  x_q, y_q;
  logic              done_pend_q;
  logic              frame_done_q, frame_err_q;
  logic [15:0]       frame_count_q;

  logic              vsync, href, pix_word, out_free, beat_acc;
  logic              load, trunc, line_end, frame_end;
  logic [CNT_W-1:0]  x_cur, y_cur;

  assign vsync    = fifo_dout[VsyncIdx];
  assign href     = fifo_dout[HrefIdx];
  assign pix_word = href && !vsync;
  assign out_free = !m_axis_video.tvalid || m_axis_video.tready;
  assign beat_acc = m_axis_video.tvalid && m_axis_video.tready;

  // A pixel waiting in VBLANK is left in the FIFO while a stalled beat still occupies the register
  always_comb begin
    fifo_rd_en = 1'b0;
    case (state_q)
      StSync:   fifo_rd_en = !fifo_empty;
      StVblank: fifo_rd_en = !fifo_empty && (!pix_word || out_free);
      StActive: fifo_rd_en = !fifo_empty && out_free;
      default:  fifo_rd_en = 1'b0;
    endcase
  end

  assign load  = fifo_rd_en && pix_word && (state_q == StVblank || state_q == StActive);
  assign trunc = fifo_rd_en && vsync && (state_q == StActive);

  // The first beat of a frame is loaded from VBLANK, where the position is implicitly (0,0)
  assign x_cur     = (state_q == StActive) ? x_q : '0;
  assign y_cur     = (state_q == StActive) ? y_q : '0;
  assign line_end  = (x_cur == CNT_W'(H_ACTIVE - 1));
  assign frame_end = line_end && (y_cur == CNT_W'(V_ACTIVE - 1));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= StIdle;
      x_q           <= '0;
      y_q           <= '0;
      done_pend_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      // The frame only counts once its final beat has left the output register
      if (done_pend_q && beat_acc) begin
        frame_done_q  <= 1'b1;
        frame_count_q <= frame_count_q + 16'd1;
        done_pend_q   <= 1'b0;
      end
      case (state_q)
        StIdle: if (enable) state_q <= StSync;
        StSync: if (fifo_rd_en && vsync) state_q <= StVblank;
        StVblank, StActive: begin
          if (trunc) begin
            frame_err_q <= 1'b1;
            x_q         <= '0;
            y_q         <= '0;
            state_q     <= enable ? StVblank : StIdle;
          end else if (load) begin
            if (frame_end) begin
              x_q         <= '0;
              y_q         <= '0;
              done_pend_q <= 1'b1;
              state_q     <= enable ? StSync : StIdle;
            end else if (line_end) begin
              x_q     <= '0;
              y_q     <= y_cur + CNT_W'(1);
              state_q <= StActive;
            end else begin
              x_q     <= x_cur + CNT_W'(1);
              y_q     <= y_cur;
              state_q <= StActive;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  axis_out_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk     (clk),
    .aresetn (aresetn),
    .load    (load),
    .data    (fifo_dout[DATA_W-1:0]),
    .user    (state_q == StVblank),
    .last    (line_end),
    .axis    (m_axis_video)
  );

  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_cam_stream_sequencer.sv
// Randomised bench for cam_stream_sequencer (4x2 frames) against a pixel-count frame model.
module tb_cam_stream_sequencer;
  localparam int unsigned DW = 16;
  localparam int unsigned H  = 4;
  localparam int unsigned V  = 2;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable = 1'b0;
  logic [DW+1:0] fifo_dout = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic          frame_done, frame_err, busy;
  logic [15:0]   frame_count;

  cam_stream_sequencer_if #(.DATA_W(DW)) axis ();

  cam_stream_sequencer #(
    .DATA_W   (DW),
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .CNT_W    (10)
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .enable       (enable),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .m_axis_video (axis),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .frame_count  (frame_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  logic [DW+1:0] fifo_q[$];   // words waiting in the modelled FIFO
  logic [DW+1:0] stim_q[$];   // words of the current scenario
  logic [DW+1:0] rx_q[$];     // accepted beats {tuser, tlast, tdata}
  logic [DW+1:0] exp_q[$];
  int            ready_mode = 0;
  int            bubbles = 0;
  int            cyc = 0;
  int            done_seen = 0, err_seen = 0;
  int            exp_done = 0, exp_err = 0;
  int            checks = 0, passed = 0;
  logic [15:0]   exp_frame_count = '0;

  // FIFO/sink driver and bus monitor: inputs change at negedge, outputs sampled 1 ns later
  initial begin
    logic          stall_prev;
    logic [DW+1:0] beat_prev, beat;
    stall_prev = 1'b0;
    beat_prev  = '0;
    axis.tready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      fifo_empty = (fifo_q.size() == 0) || (bubbles != 0 && $urandom_range(0, 3) == 0);
      fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
      case (ready_mode)
        0:       axis.tready = 1'b1;
        1:       axis.tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: axis.tready = ($urandom_range(0, 9) < 7);
      endcase
      #1;
      if (!aresetn) begin
        stall_prev = 1'b0;
        continue;
      end
      beat = {axis.tuser, axis.tlast, axis.tdata};
      if (stall_prev) begin
        checks++;
        if (axis.tvalid !== 1'b1 || beat !== beat_prev)
          $display("FAIL stall_hold: got valid=%b beat=%h required valid=1 beat=%h",
                   axis.tvalid, beat, beat_prev);
        else passed++;
      end
      if (axis.tvalid && !axis.tready && fifo_q.size() != 0 && fifo_q[0][DW+1:DW] == 2'b01) begin
        checks++;
        if (fifo_rd_en !== 1'b0)
          $display("FAIL rd_en_stall: got fifo_rd_en=%b required 0", fifo_rd_en);
        else passed++;
      end
      if (fifo_empty) begin
        checks++;
        if (fifo_rd_en !== 1'b0)
          $display("FAIL rd_en_empty: got fifo_rd_en=%b required 0", fifo_rd_en);
        else passed++;
      end
      if (axis.tvalid && axis.tready) rx_q.push_back(beat);
      if (fifo_rd_en && fifo_q.size() != 0) void'(fifo_q.pop_front());
      if (frame_done === 1'b1) done_seen++;
      if (frame_err === 1'b1) err_seen++;
      if (frame_done === 1'b1 || frame_err === 1'b1) begin
        checks++;
        if (frame_done === 1'b1 && frame_err === 1'b1)
          $display("FAIL done_err_overlap: got done=1 err=1 required at most one");
        else passed++;
      end
      stall_prev = axis.tvalid && !axis.tready;
      beat_prev  = beat;
    end
  end

  // Frame model: pixels are counted from the first active pixel after a vsync; a frame is
  // complete after H*V of them and a vsync arriving earlier truncates it.
  task automatic model_run();
    int phase = 0;  // 0 hunting vsync, 1 in vertical blank, 2 inside the frame
    int n = 0;
    foreach (stim_q[i]) begin
      logic v, h;
      v = stim_q[i][DW+1];
      h = stim_q[i][DW];
      if (phase == 0) begin
        if (v) phase = 1;
      end else if (phase == 2 && v) begin
        exp_err++;
        n = 0;
        phase = 1;
      end else if (!v && h) begin
        exp_q.push_back({n == 0, (n % H) == (H - 1), stim_q[i][DW-1:0]});
        n++;
        if (n == H * V) begin
          exp_done++;
          n = 0;
          phase = 0;
        end else phase = 2;
      end
    end
  endtask

  task automatic add_frame(input int n_vs, input int n_bl, input int n_pix, input int hb_pos,
                           input int hb_pct, input int base);
    logic [DW-1:0] d;
    for (int i = 0; i < n_vs; i++) stim_q.push_back({2'b10, 16'($urandom)});
    for (int i = 0; i < n_bl; i++) stim_q.push_back({2'b00, 16'($urandom)});
    for (int i = 0; i < n_pix; i++) begin
      if (i == hb_pos || (i != 0 && $urandom_range(0, 99) < hb_pct))
        stim_q.push_back({2'b00, 16'($urandom)});
      d = (base > 0) ? 16'(base + i) : 16'($urandom);
      stim_q.push_back({2'b01, d});
    end
  endtask

  task automatic run_scenario(input string name, input int budget);
    int c = 0, idle = 0, done0, err0;
    exp_q.delete();
    rx_q.delete();
    exp_done = 0;
    exp_err  = 0;
    done0 = done_seen;
    err0  = err_seen;
    model_run();
    foreach (stim_q[i]) fifo_q.push_back(stim_q[i]);
    stim_q.delete();
    while (idle < 4 && c < budget) begin
      @(negedge clk);
      #2;
      c++;
      if (fifo_q.size() == 0 && !axis.tvalid) idle++;
      else idle = 0;
    end
    checks++;
    if (c >= budget) $display("FAIL %s_timeout: got %0d cycles required < %0d", name, c, budget);
    else passed++;
    exp_frame_count = exp_frame_count + 16'(exp_done);
    checks++;
    if (rx_q.size() != exp_q.size())
      $display("FAIL %s_beat_count: got %0d required %0d", name, rx_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i])
        $display("FAIL %s_beat%0d: got %h required %h", name, i, rx_q[i], exp_q[i]);
      else passed++;
    end
    checks++;
    if (done_seen - done0 != exp_done)
      $display("FAIL %s_frame_done: got %0d required %0d", name, done_seen - done0, exp_done);
    else passed++;
    checks++;
    if (err_seen - err0 != exp_err)
      $display("FAIL %s_frame_err: got %0d required %0d", name, err_seen - err0, exp_err);
    else passed++;
    checks++;
    if (frame_count !== exp_frame_count)
      $display("FAIL %s_frame_count: got %0d required %0d", name, frame_count, exp_frame_count);
    else passed++;
  endtask

  task automatic check_beat(input string name, input int idx, input logic [DW+1:0] want);
    checks++;
    if (idx >= rx_q.size()) $display("FAIL %s: got no beat %0d required %h", name, idx, want);
    else if (rx_q[idx] !== want) $display("FAIL %s: got %h required %h", name, rx_q[idx], want);
    else passed++;
  endtask

  task automatic test_reset();
    logic [8:0] outs;
    for (int i = 0; i < 3; i++) fifo_q.push_back({2'b10, 16'h00ff});
    repeat (3) @(negedge clk);
    #2;
    outs = {fifo_rd_en, axis.tvalid, axis.tuser, axis.tlast, frame_done, frame_err, busy,
            |axis.tdata, |frame_count};
    checks++;
    if (outs !== 9'b0) $display("FAIL reset_outputs: got %b required 000000000", outs);
    else passed++;
    aresetn = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    checks++;
    if (busy !== 1'b0 || fifo_rd_en !== 1'b0)
      $display("FAIL idle_disabled: got busy=%b rd_en=%b required 0 0", busy, fifo_rd_en);
    else passed++;
    checks++;
    if (fifo_q.size() != 3) $display("FAIL idle_no_pop: got %0d words required 3", fifo_q.size());
    else passed++;
    fifo_q.delete();
    enable = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (busy !== 1'b1) $display("FAIL busy_enabled: got %b required 1", busy);
    else passed++;
  endtask

  task automatic test_clean_frame();
    ready_mode = 0;
    bubbles = 0;
    add_frame(3, 2, 8, -1, 0, 1);
    run_scenario("clean", 400);
    check_beat("clean_first_tuser", 0, 18'h20001);
    check_beat("clean_line0_tlast", 3, 18'h10004);
    check_beat("clean_line1_tlast", 7, 18'h10008);
  endtask

  task automatic test_backpressure();
    ready_mode = 1;
    add_frame(3, 2, 8, -1, 0, 1);
    add_frame(2, 1, 8, -1, 0, 0);
    run_scenario("backpressure", 600);
  endtask

  task automatic test_truncation();
    ready_mode = 0;
    add_frame(3, 2, 5, -1, 0, 1);
    add_frame(2, 1, 8, -1, 0, 16'h11);
    run_scenario("truncation", 600);
    check_beat("trunc_next_tuser", 5, 18'h20011);
  endtask

  task automatic test_hblank();
    ready_mode = 2;
    add_frame(3, 2, 8, 2, 0, 1);
    run_scenario("hblank", 600);
    check_beat("hblank_pix3", 2, 18'h00003);
  endtask

  task automatic test_random_frames();
    int k;
    ready_mode = 2;
    bubbles = 1;
    for (int f = 0; f < 6; f++) begin
      k = (f != 5 && $urandom_range(0, 3) == 0) ? $urandom_range(1, H * V - 1) : H * V;
      add_frame($urandom_range(1, 3), $urandom_range(0, 3), k, -1, 25, 0);
    end
    run_scenario("random", 3000);
    bubbles = 0;
  endtask

  task automatic test_async_reset();
    int c = 0;
    ready_mode = 0;
    add_frame(3, 2, 8, -1, 0, 16'h21);
    rx_q.delete();
    foreach (stim_q[i]) fifo_q.push_back(stim_q[i]);
    stim_q.delete();
    while (rx_q.size() < 3 && c < 200) begin
      @(negedge clk);
      #2;
      c++;
    end
    checks++;
    if (rx_q.size() < 3) $display("FAIL areset_wait: got %0d beats required 3", rx_q.size());
    else passed++;
    aresetn = 1'b0;
    #1;
    checks++;
    if (axis.tvalid !== 1'b0 || busy !== 1'b0 || frame_count !== 16'd0)
      $display("FAIL areset_immediate: got valid=%b busy=%b count=%0d required 0 0 0",
               axis.tvalid, busy, frame_count);
    else passed++;
    @(negedge clk);
    #2;
    aresetn = 1'b1;
    exp_frame_count = '0;
    add_frame(2, 2, 8, -1, 0, 16'h41);
    run_scenario("resync", 600);
    check_beat("resync_first_tuser", 0, 18'h20041);
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_backpressure();
    test_truncation();
    test_hblank();
    test_random_frames();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
